// File: rtl/writeback_queue.sv
// Writeback queue: merges load and ALU results into one ordered register-bank write stream.
// Loads win arbitration; the bank is written from the head entry whenever wb_hold is low.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_rd,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  input  logic        wb_hold,
  output logic [2:0]  rd,
  output logic [15:0] Datain,
  output logic        registerLoad,
  output logic [7:0]  busy_mask,
  output logic [3:0]  count
);

  localparam int DATA_W = 16;
  localparam int RD_W   = 3;
  localparam int PTR_W  = $clog2(DEPTH);

  logic [RD_W-1:0]   slot_rd   [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]  slot_vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              not_full;
  logic              not_empty;
  logic              push_mem;
  logic              push_alu;
  logic              push;
  logic              pop;
  logic [RD_W-1:0]   push_rd;
  logic [DATA_W-1:0] push_data;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) next_ptr = '0;
    else                        next_ptr = p + 1'b1;
  endfunction

  // Readies are a function of occupancy and mem_valid only, forced low in reset.
  assign not_full  = (count < 4'(DEPTH));
  assign not_empty = (count != 4'd0);
  assign mem_ready = rst_n & not_full;
  assign alu_ready = rst_n & not_full & ~mem_valid;

  assign push_mem  = mem_valid & mem_ready;
  assign push_alu  = alu_valid & alu_ready;
  assign push      = push_mem | push_alu;
  assign push_rd   = push_mem ? mem_rd   : alu_rd;
  assign push_data = push_mem ? mem_data : alu_data;

  assign registerLoad = not_empty & ~wb_hold;
  assign pop          = registerLoad;
  assign rd           = not_empty ? slot_rd[rd_ptr]   : '0;
  assign Datain       = not_empty ? slot_data[rd_ptr] : '0;

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) busy_mask[slot_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      slot_vld <= '0;
    end else begin
      // Push and pop never target the same slot: empty blocks pop, full blocks push.
      if (pop) begin
        rd_ptr           <= next_ptr(rd_ptr);
        slot_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr           <= next_ptr(wr_ptr);
        slot_vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; slot_vld and count qualify every read.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_rd[wr_ptr]   <= push_rd;
      slot_data[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every register-bank write the DUT issues.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        wb_hold;
  logic [2:0]  rd;
  logic [15:0] Datain;
  logic        registerLoad;
  logic [7:0]  busy_mask;
  logic [3:0]  count;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_hold(wb_hold), .rd(rd), .Datain(Datain), .registerLoad(registerLoad),
    .busy_mask(busy_mask), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [2:0] r, input logic [15:0] d);
    alu_valid = 1'b1;
    alu_rd    = r;
    alu_data  = d;
    exp_q.push_back({r, d});
  endtask

  // Monitor: every write the DUT issues must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (registerLoad === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'({rd, Datain}), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_rd",   32'(rd),     32'(mon_e.rd));
          chk("wb_data", 32'(Datain), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wb_hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_count",     32'(count),        32'd0);
    chk("rst_busy",      32'(busy_mask),    32'd0);
    chk("rst_regload",   32'(registerLoad), 32'd0);
    chk("rst_rd",        32'(rd),           32'd0);
    chk("rst_datain",    32'(Datain),       32'd0);
    chk("rst_mem_ready", 32'(mem_ready),    32'd0);
    chk("rst_alu_ready", 32'(alu_ready),    32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_mem_ready", 32'(mem_ready), 32'd1);
    chk("rel_alu_ready", 32'(alu_ready), 32'd1);

    // Single write, accepted on the first edge after reset release
    drive_alu(3'd3, 16'h1234);
    tick();
    alu_valid = 1'b0;
    chk("single_regload", 32'(registerLoad), 32'd1);
    chk("single_rd",      32'(rd),           32'd3);
    chk("single_data",    32'(Datain),       32'h1234);
    chk("single_busy",    32'(busy_mask),    32'h08);
    chk("single_count",   32'(count),        32'd1);
    tick();
    chk("single_count0",  32'(count),        32'd0);
    chk("single_busy0",   32'(busy_mask),    32'd0);

    // Load beats ALU in the same cycle
    mem_valid = 1'b1; mem_rd = 3'd1; mem_data = 16'hAAAA;
    exp_q.push_back({3'd1, 16'hAAAA});
    drive_alu(3'd2, 16'h5555);
    #1;
    chk("prio_alu_ready", 32'(alu_ready), 32'd0);
    chk("prio_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    chk("prio_count1", 32'(count),     32'd1);
    chk("prio_busy1",  32'(busy_mask), 32'h02);
    #1;
    chk("prio_alu_ready2", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    chk("prio_count2", 32'(count),     32'd1);
    chk("prio_busy2",  32'(busy_mask), 32'h04);
    tick();
    chk("prio_count0", 32'(count), 32'd0);

    // Fill under hold, then full-cycle pop with a load offered
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_alu(3'(4 + i), 16'hC000 + 16'(i));
      tick();
    end
    alu_valid = 1'b0;
    chk("full_count",     32'(count),        32'd4);
    chk("full_mem_ready", 32'(mem_ready),    32'd0);
    chk("full_alu_ready", 32'(alu_ready),    32'd0);
    chk("full_regload",   32'(registerLoad), 32'd0);
    chk("full_busy",      32'(busy_mask),    32'hF0);
    mem_valid = 1'b1; mem_rd = 3'd0; mem_data = 16'hDEAD;
    tick();
    chk("full_nopush", 32'(count), 32'd4);
    wb_hold = 1'b0;
    tick();
    mem_valid = 1'b0;
    chk("drain_count3", 32'(count), 32'd3);
    for (int i = 2; i >= 0; i--) begin
      tick();
      chk("drain_count", 32'(count), 32'(i));
    end

    // Pointer wrap with back-to-back push/pop
    for (int i = 0; i < 10; i++) begin
      drive_alu(3'(i % 8), 16'(i));
      tick();
      chk("wrap_count", 32'(count), 32'd1);
    end
    alu_valid = 1'b0;
    tick();
    chk("wrap_count0", 32'(count), 32'd0);

    // Two entries to the same register
    wb_hold = 1'b1;
    drive_alu(3'd5, 16'h0001);
    tick();
    drive_alu(3'd5, 16'h0002);
    tick();
    alu_valid = 1'b0;
    chk("same_count2", 32'(count),     32'd2);
    chk("same_busy2",  32'(busy_mask), 32'h20);
    wb_hold = 1'b0;
    tick();
    chk("same_count1", 32'(count),     32'd1);
    chk("same_busy1",  32'(busy_mask), 32'h20);
    tick();
    chk("same_count0", 32'(count),     32'd0);
    chk("same_busy0",  32'(busy_mask), 32'h00);

    // Asynchronous reset with three entries queued
    wb_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_alu(3'(i), 16'hB000 + 16'(i));
      tick();
    end
    alu_valid = 1'b0;
    chk("mid_count3", 32'(count), 32'd3);
    wb_hold = 1'b0;
    #1;
    chk("mid_regload1", 32'(registerLoad), 32'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_regload0", 32'(registerLoad), 32'd0);
    chk("mid_count0",   32'(count),        32'd0);
    chk("mid_busy0",    32'(busy_mask),    32'd0);
    chk("mid_rd0",      32'(rd),           32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_count", 32'(count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
